// File: rtl/mlp_engine.sv
// Two-layer MLP inference engine: Linear -> ReLU/requantise -> Linear -> argmax.
// Latency: H*(N_IN+2) + N_OUT*(H+2) + 1 cycles from the edge sampling start to done.
// No backpressure: ROMs answer in one cycle; pixel writes outside IDLE/DONE are dropped.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start, abort            start (rising edge, IDLE only), abort (level, busy states)
//   busy, done              running indicator, one-cycle completion pulse
//   pix_we/addr/data, pix_err  pixel buffer write port, sticky rejected-write flag
//   w1_*, b1_*, w2_*, b2_*  1-cycle-latency weight/bias ROM ports
//   predicted, best_score   argmax class and its score, updated with done
//   score_rd_addr/data      combinational per-class score read (0 when out of range)
module mlp_engine #(
  parameter int N_IN  = 784,
  parameter int H     = 32,
  parameter int N_OUT = 10,
  parameter int X_W   = 8,
  parameter int W_W   = 8,
  parameter int B_W   = 32,
  parameter int ACC_W = 48,
  parameter int A_W   = 16,
  parameter int SHIFT = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  input  logic                          pix_we,
  input  logic [$clog2(N_IN)-1:0]       pix_addr,
  input  logic [X_W-1:0]                pix_data,
  output logic                          pix_err,
  output logic                          w1_en,
  output logic [$clog2(N_IN*H)-1:0]     w1_addr,
  input  logic signed [W_W-1:0]         w1_dout,
  output logic                          b1_en,
  output logic [$clog2(H)-1:0]          b1_addr,
  input  logic signed [B_W-1:0]         b1_dout,
  output logic                          w2_en,
  output logic [$clog2(H*N_OUT)-1:0]    w2_addr,
  input  logic signed [W_W-1:0]         w2_dout,
  output logic                          b2_en,
  output logic [$clog2(N_OUT)-1:0]      b2_addr,
  input  logic signed [B_W-1:0]         b2_dout,
  output logic [$clog2(N_OUT)-1:0]      predicted,
  output logic signed [ACC_W-1:0]       best_score,
  input  logic [$clog2(N_OUT)-1:0]      score_rd_addr,
  output logic signed [ACC_W-1:0]       score_rd_data
);
  localparam int AI  = $clog2(N_IN);
  localparam int AH  = $clog2(H);
  localparam int AO  = $clog2(N_OUT);
  localparam int AW1 = $clog2(N_IN*H);
  localparam int AW2 = $clog2(H*N_OUT);

  localparam logic [AI-1:0] I_LAST = AI'(N_IN-1);
  localparam logic [AH-1:0] H_LAST = AH'(H-1);
  localparam logic [AO-1:0] O_LAST = AO'(N_OUT-1);

  // Largest positive hidden activation, at activation and accumulator width.
  localparam logic signed [A_W-1:0]   A_MAX_S = {1'b0, {(A_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] A_MAX   = {{(ACC_W-A_W+1){1'b0}}, {(A_W-1){1'b1}}};

  typedef enum logic [2:0] {
    IDLE, L1_PRIME, L1_MAC, L1_STORE, L2_PRIME, L2_MAC, L2_FINISH, DONE
  } state_t;

  state_t                  state;
  logic                    start_q, start_q2;
  logic [AI-1:0]           i_cnt;
  logic [AH-1:0]           j_cnt;
  logic [AO-1:0]           k_cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] best_val;
  logic [AO-1:0]           best_idx;

  logic [X_W-1:0]          pix_mem   [N_IN];
  logic signed [A_W-1:0]   act_mem   [H];
  logic signed [ACC_W-1:0] score_mem [N_OUT];

  // Datapath
  logic signed [W_W+X_W:0]   prod1;
  logic signed [W_W+A_W-1:0] prod2;
  logic signed [ACC_W-1:0]   prod1_ext, prod2_ext, b1_ext, b2_ext;
  logic signed [ACC_W-1:0]   h_sum, h_shr, score_sum, best_next;
  logic signed [A_W-1:0]     act_new;
  logic [AO-1:0]             idx_next;
  logic                      take_best;
  logic                      pix_ok;

  // Pixels are unsigned: a zero MSB makes them positive in the signed product.
  assign prod1     = w1_dout * $signed({1'b0, pix_mem[i_cnt]});
  assign prod2     = w2_dout * act_mem[j_cnt];
  assign prod1_ext = {{(ACC_W-W_W-X_W-1){prod1[W_W+X_W]}}, prod1};
  assign prod2_ext = {{(ACC_W-W_W-A_W){prod2[W_W+A_W-1]}}, prod2};
  assign b1_ext    = {{(ACC_W-B_W){b1_dout[B_W-1]}}, b1_dout};
  assign b2_ext    = {{(ACC_W-B_W){b2_dout[B_W-1]}}, b2_dout};

  assign h_sum     = acc + b1_ext;
  assign h_shr     = h_sum >>> SHIFT;
  assign score_sum = acc + b2_ext;

  // ReLU then saturate to the positive activation range.
  always_comb begin
    act_new = '0;
    if (!h_sum[ACC_W-1] && (h_sum != '0)) begin
      if (h_shr > A_MAX) act_new = A_MAX_S;
      else               act_new = h_shr[A_W-1:0];
    end
  end

  // Class 0 seeds the running best; strict compare keeps the lowest index on ties.
  assign take_best = (k_cnt == '0) || (score_sum > best_val);
  assign best_next = take_best ? score_sum : best_val;
  assign idx_next  = take_best ? k_cnt : best_idx;

  assign pix_ok = ((state == IDLE) || (state == DONE)) && (32'(pix_addr) < N_IN);

  always_comb begin
    score_rd_data = '0;
    if (32'(score_rd_addr) < N_OUT) score_rd_data = score_mem[score_rd_addr];
  end

  // Pixel buffer is plain storage, left out of reset.
  always_ff @(posedge clk) begin
    if (pix_we && pix_ok) pix_mem[pix_addr] <= pix_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      start_q2   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pix_err    <= 1'b0;
      w1_en      <= 1'b0;
      b1_en      <= 1'b0;
      w2_en      <= 1'b0;
      b2_en      <= 1'b0;
      w1_addr    <= '0;
      b1_addr    <= '0;
      w2_addr    <= '0;
      b2_addr    <= '0;
      predicted  <= '0;
      best_score <= '0;
      acc        <= '0;
      i_cnt      <= '0;
      j_cnt      <= '0;
      k_cnt      <= '0;
      best_val   <= '0;
      best_idx   <= '0;
      for (int n = 0; n < N_OUT; n++) score_mem[n] <= '0;
      for (int n = 0; n < H; n++)     act_mem[n]   <= '0;
    end else begin
      start_q  <= start;
      start_q2 <= start_q;
      done     <= 1'b0;
      if (pix_we && !pix_ok) pix_err <= 1'b1;

      if (busy && abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        w1_en <= 1'b0;
        b1_en <= 1'b0;
        w2_en <= 1'b0;
        b2_en <= 1'b0;
        acc   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_q && !start_q2) begin
              pix_err <= 1'b0;
              busy    <= 1'b1;
              w1_en   <= 1'b1;
              b1_en   <= 1'b1;
              w1_addr <= '0;
              b1_addr <= '0;
              acc     <= '0;
              i_cnt   <= '0;
              j_cnt   <= '0;
              k_cnt   <= '0;
              for (int n = 0; n < N_OUT; n++) score_mem[n] <= '0;
              state   <= L1_PRIME;
            end
          end
          // Address is prefetched one ahead so dout lines up with the MAC index.
          L1_PRIME: begin
            w1_addr <= w1_addr + AW1'(1);
            i_cnt   <= '0;
            state   <= L1_MAC;
          end
          L1_MAC: begin
            acc <= acc + prod1_ext;
            if (i_cnt == I_LAST) begin
              state <= L1_STORE;
            end else begin
              i_cnt   <= i_cnt + AI'(1);
              w1_addr <= w1_addr + AW1'(1);
            end
          end
          L1_STORE: begin
            act_mem[j_cnt] <= act_new;
            acc            <= '0;
            if (j_cnt == H_LAST) begin
              w1_en   <= 1'b0;
              b1_en   <= 1'b0;
              w2_en   <= 1'b1;
              b2_en   <= 1'b1;
              w2_addr <= '0;
              b2_addr <= '0;
              j_cnt   <= '0;
              k_cnt   <= '0;
              state   <= L2_PRIME;
            end else begin
              j_cnt   <= j_cnt + AH'(1);
              b1_addr <= b1_addr + AH'(1);
              state   <= L1_PRIME;
            end
          end
          L2_PRIME: begin
            w2_addr <= w2_addr + AW2'(1);
            j_cnt   <= '0;
            state   <= L2_MAC;
          end
          L2_MAC: begin
            acc <= acc + prod2_ext;
            if (j_cnt == H_LAST) begin
              state <= L2_FINISH;
            end else begin
              j_cnt   <= j_cnt + AH'(1);
              w2_addr <= w2_addr + AW2'(1);
            end
          end
          L2_FINISH: begin
            score_mem[k_cnt] <= score_sum;
            best_val         <= best_next;
            best_idx         <= idx_next;
            acc              <= '0;
            if (k_cnt == O_LAST) begin
              busy       <= 1'b0;
              done       <= 1'b1;
              predicted  <= idx_next;
              best_score <= best_next;
              w2_en      <= 1'b0;
              b2_en      <= 1'b0;
              state      <= DONE;
            end else begin
              k_cnt   <= k_cnt + AO'(1);
              b2_addr <= b2_addr + AO'(1);
              state   <= L2_PRIME;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mlp_engine.sv
// Bench for mlp_engine: a small instance (4-2-3, SHIFT=0, A_W=8) for arithmetic
// cases and a default-parameter instance for latency, abort and range checks.
// Expected results are queued at start; monitors compare on each done pulse.
module tb_mlp_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  // ---------------- small instance ----------------
  logic               s_rst_n, s_start, s_abort, s_busy, s_done, s_pix_we, s_pix_err;
  logic [1:0]         s_pix_addr;
  logic [7:0]         s_pix_data;
  logic               s_w1_en, s_b1_en, s_w2_en, s_b2_en;
  logic [2:0]         s_w1_addr, s_w2_addr;
  logic [0:0]         s_b1_addr;
  logic [1:0]         s_b2_addr, s_predicted, s_score_rd_addr;
  logic signed [7:0]  s_w1_dout, s_w2_dout;
  logic signed [31:0] s_b1_dout, s_b2_dout;
  logic signed [47:0] s_best_score, s_score_rd_data;

  logic signed [7:0]  s_w1_mem [8];
  logic signed [31:0] s_b1_mem [2];
  logic signed [7:0]  s_w2_mem [8];
  logic signed [31:0] s_b2_mem [4];

  always @(posedge clk) begin
    if (s_w1_en) s_w1_dout <= s_w1_mem[s_w1_addr];
    if (s_b1_en) s_b1_dout <= s_b1_mem[s_b1_addr];
    if (s_w2_en) s_w2_dout <= s_w2_mem[s_w2_addr];
    if (s_b2_en) s_b2_dout <= s_b2_mem[s_b2_addr];
  end

  mlp_engine #(.N_IN(4), .H(2), .N_OUT(3), .A_W(8), .SHIFT(0)) u_small (
    .clk(clk), .rst_n(s_rst_n), .start(s_start), .abort(s_abort),
    .busy(s_busy), .done(s_done),
    .pix_we(s_pix_we), .pix_addr(s_pix_addr), .pix_data(s_pix_data), .pix_err(s_pix_err),
    .w1_en(s_w1_en), .w1_addr(s_w1_addr), .w1_dout(s_w1_dout),
    .b1_en(s_b1_en), .b1_addr(s_b1_addr), .b1_dout(s_b1_dout),
    .w2_en(s_w2_en), .w2_addr(s_w2_addr), .w2_dout(s_w2_dout),
    .b2_en(s_b2_en), .b2_addr(s_b2_addr), .b2_dout(s_b2_dout),
    .predicted(s_predicted), .best_score(s_best_score),
    .score_rd_addr(s_score_rd_addr), .score_rd_data(s_score_rd_data)
  );

  // ---------------- default instance ----------------
  logic               d_rst_n, d_start, d_abort, d_busy, d_done, d_pix_we, d_pix_err;
  logic [9:0]         d_pix_addr;
  logic [7:0]         d_pix_data;
  logic               d_w1_en, d_b1_en, d_w2_en, d_b2_en;
  logic [14:0]        d_w1_addr;
  logic [4:0]         d_b1_addr;
  logic [8:0]         d_w2_addr;
  logic [3:0]         d_b2_addr, d_predicted, d_score_rd_addr;
  logic signed [7:0]  d_w1_dout, d_w2_dout;
  logic signed [31:0] d_b1_dout, d_b2_dout;
  logic signed [47:0] d_best_score, d_score_rd_data;

  // All weights and layer-1 biases zero, so scores equal b2: 3*k except class 7 = 100.
  assign d_w1_dout = '0;
  assign d_w2_dout = '0;
  assign d_b1_dout = '0;
  always @(posedge clk) begin
    if (d_b2_en) d_b2_dout <= (d_b2_addr == 4'd7) ? 32'sd100 : 32'(d_b2_addr) * 32'sd3;
  end

  mlp_engine u_default (
    .clk(clk), .rst_n(d_rst_n), .start(d_start), .abort(d_abort),
    .busy(d_busy), .done(d_done),
    .pix_we(d_pix_we), .pix_addr(d_pix_addr), .pix_data(d_pix_data), .pix_err(d_pix_err),
    .w1_en(d_w1_en), .w1_addr(d_w1_addr), .w1_dout(d_w1_dout),
    .b1_en(d_b1_en), .b1_addr(d_b1_addr), .b1_dout(d_b1_dout),
    .w2_en(d_w2_en), .w2_addr(d_w2_addr), .w2_dout(d_w2_dout),
    .b2_en(d_b2_en), .b2_addr(d_b2_addr), .b2_dout(d_b2_dout),
    .predicted(d_predicted), .best_score(d_best_score),
    .score_rd_addr(d_score_rd_addr), .score_rd_data(d_score_rd_data)
  );

  // ---------------- scoreboards ----------------
  typedef struct packed {
    logic [63:0]       pred;
    logic [63:0]       best;
    logic [3:0][63:0]  sc;   // index 3 is out of range and must read 0
  } s_exp_t;
  typedef struct packed {
    logic [63:0] pred;
    logic [63:0] best;
  } d_exp_t;

  s_exp_t q_s[$];
  d_exp_t q_d[$];
  int     d_done_cnt = 0;

  function automatic void s_expect(input longint p, input longint b,
                                   input longint c0, input longint c1, input longint c2);
    s_exp_t e;
    e.pred = p; e.best = b;
    e.sc[0] = c0; e.sc[1] = c1; e.sc[2] = c2; e.sc[3] = 0;
    q_s.push_back(e);
  endfunction

  initial begin : mon_small
    s_exp_t e;
    forever begin
      @(negedge clk);
      if (s_done) begin
        check("s_done_expected", longint'(q_s.size() != 0), 1);
        if (q_s.size() != 0) begin
          e = q_s.pop_front();
          check("s_predicted", longint'(s_predicted), $signed(e.pred));
          check("s_best_score", longint'(s_best_score), $signed(e.best));
          for (int a = 0; a < 4; a++) begin
            s_score_rd_addr = 2'(a);
            #1;
            check($sformatf("s_score[%0d]", a), longint'(s_score_rd_data), $signed(e.sc[a]));
          end
        end
      end
    end
  end

  initial begin : mon_default
    d_exp_t e;
    forever begin
      @(negedge clk);
      if (d_done) begin
        d_done_cnt++;
        check("d_done_expected", longint'(q_d.size() != 0), 1);
        if (q_d.size() != 0) begin
          e = q_d.pop_front();
          check("d_predicted", longint'(d_predicted), $signed(e.pred));
          check("d_best_score", longint'(d_best_score), $signed(e.best));
          d_score_rd_addr = 4'd7;
          #1 check("d_score[7]", longint'(d_score_rd_data), 100);
          d_score_rd_addr = 4'd12;
          #1 check("d_score[12]", longint'(d_score_rd_data), 0);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic s_pix(input int a, input int v);
    @(negedge clk);
    s_pix_we = 1'b1; s_pix_addr = 2'(a); s_pix_data = 8'(v);
    @(negedge clk);
    s_pix_we = 1'b0;
  endtask

  task automatic s_pix_all(input int v0, input int v1, input int v2, input int v3);
    s_pix(0, v0); s_pix(1, v1); s_pix(2, v2); s_pix(3, v3);
  endtask

  task automatic s_start_pulse();
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
  endtask

  task automatic s_run(input string name);
    s_start_pulse();
    repeat (35) @(negedge clk);
    check({name, "_completed"}, longint'(q_s.size()), 0);
  endtask

  // Golden vector: a = {10, 6}, scores {10, 12, 11}.
  task automatic s_load_golden();
    s_w1_mem[0] = 1;  s_w1_mem[1] = 1; s_w1_mem[2] = 1; s_w1_mem[3] = 1;
    s_w1_mem[4] = -1; s_w1_mem[5] = 0; s_w1_mem[6] = 0; s_w1_mem[7] = 2;
    s_b1_mem[0] = 0;  s_b1_mem[1] = -1;
    s_w2_mem[0] = 1;  s_w2_mem[1] = 0; s_w2_mem[2] = 0; s_w2_mem[3] = 2;
    s_w2_mem[4] = 1;  s_w2_mem[5] = 1; s_w2_mem[6] = 0; s_w2_mem[7] = 0;
    s_b2_mem[0] = 0;  s_b2_mem[1] = 0; s_b2_mem[2] = -5; s_b2_mem[3] = 0;
    s_pix_all(1, 2, 3, 4);
  endtask

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int cyc, found, gaps;
    s_rst_n = 1'b0; s_start = 1'b0; s_abort = 1'b0; s_pix_we = 1'b0;
    s_pix_addr = '0; s_pix_data = '0; s_score_rd_addr = '0;
    d_rst_n = 1'b0; d_start = 1'b0; d_abort = 1'b0; d_pix_we = 1'b0;
    d_pix_addr = '0; d_pix_data = '0; d_score_rd_addr = '0;
    for (int n = 0; n < 8; n++) begin s_w1_mem[n] = 0; s_w2_mem[n] = 0; end
    for (int n = 0; n < 4; n++) s_b2_mem[n] = 0;
    s_b1_mem[0] = 0; s_b1_mem[1] = 0;

    repeat (3) @(negedge clk);
    check("s_rst_busy", s_busy, 0);
    check("s_rst_done", s_done, 0);
    check("s_rst_pix_err", s_pix_err, 0);
    check("s_rst_w1_en", s_w1_en, 0);
    check("s_rst_predicted", s_predicted, 0);
    check("s_rst_score0", s_score_rd_data, 0);
    check("d_rst_busy", d_busy, 0);
    check("d_rst_best_score", d_best_score, 0);
    s_rst_n = 1'b1; d_rst_n = 1'b1;

    // Golden run with a write attempted mid-run; the rerun proves the buffer kept its data.
    s_load_golden();
    s_expect(1, 12, 10, 12, 11);
    s_start_pulse();
    repeat (2) @(negedge clk);
    s_pix_we = 1'b1; s_pix_addr = 2'd0; s_pix_data = 8'd200;
    @(negedge clk);
    s_pix_we = 1'b0;
    check("s_pix_err_set", s_pix_err, 1);
    repeat (35) @(negedge clk);
    check("s_golden_completed", longint'(q_s.size()), 0);
    check("s_pix_err_sticky", s_pix_err, 1);
    s_expect(1, 12, 10, 12, 11);
    s_start_pulse();
    @(negedge clk);
    check("s_pix_err_cleared", s_pix_err, 0);
    repeat (35) @(negedge clk);
    check("s_rerun_completed", longint'(q_s.size()), 0);

    // Tie-break: zero activations, scores are b2 = {5, 9, 9}.
    s_b1_mem[1] = 0;
    s_b2_mem[0] = 5; s_b2_mem[1] = 9; s_b2_mem[2] = 9;
    s_pix_all(0, 0, 0, 0);
    s_expect(1, 9, 5, 9, 9);
    s_run("s_tie");

    // Saturation: 4*255*127 = 129540 clips to 127; scores 2*127.
    for (int n = 0; n < 8; n++) begin s_w1_mem[n] = 127; s_w2_mem[n] = 1; end
    s_b2_mem[0] = 0; s_b2_mem[1] = 0; s_b2_mem[2] = 0;
    s_pix_all(255, 255, 255, 255);
    s_expect(0, 254, 254, 254, 254);
    s_run("s_sat");

    // ReLU: negative pre-activation gives zero, scores equal b2.
    for (int n = 0; n < 8; n++) s_w1_mem[n] = -1;
    s_b2_mem[0] = -3; s_b2_mem[1] = -1; s_b2_mem[2] = -7;
    s_pix_all(10, 10, 10, 10);
    s_expect(1, -1, -3, -1, -7);
    s_run("s_relu");

    // Reset in the middle of layer 2, then a clean golden run.
    s_load_golden();
    s_start_pulse();
    repeat (17) @(negedge clk);
    check("s_in_layer2", s_w2_en, 1);
    s_score_rd_addr = 2'd0;
    s_rst_n = 1'b0;
    #1;
    check("s_mrst_busy", s_busy, 0);
    check("s_mrst_done", s_done, 0);
    check("s_mrst_predicted", s_predicted, 0);
    check("s_mrst_best_score", s_best_score, 0);
    check("s_mrst_w2_en", s_w2_en, 0);
    check("s_mrst_w2_addr", s_w2_addr, 0);
    check("s_mrst_score0", s_score_rd_data, 0);
    repeat (2) @(negedge clk);
    s_rst_n = 1'b1;
    s_load_golden();
    s_expect(1, 12, 10, 12, 11);
    s_run("s_after_reset");

    // Default parameters: out-of-range pixel write, then exact latency.
    @(negedge clk);
    d_pix_we = 1'b1; d_pix_addr = 10'd1000; d_pix_data = 8'd5;
    @(negedge clk);
    d_pix_we = 1'b0;
    check("d_pix_err_range", d_pix_err, 1);

    q_d.push_back('{pred: 64'd7, best: 64'd100});
    @(negedge clk); d_start = 1'b1;
    @(posedge clk);
    cyc = 0; found = 0; gaps = 0;
    while (found == 0 && cyc < 26000) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 1)  d_start = 1'b0;
      if (cyc == 50) d_start = 1'b1;   // ignored while busy
      if (cyc == 52) d_start = 1'b0;
      if (cyc == 5)  check("d_pix_err_cleared", d_pix_err, 0);
      if (d_done) found = 1;
      else if (!d_busy) gaps++;
    end
    check("d_latency", (found != 0) ? cyc : -1, 25493);
    check("d_busy_gaps", gaps, 0);
    check("d_busy_at_done", d_busy, 0);
    repeat (5) @(negedge clk);
    check("d_done_count", d_done_cnt, 1);
    check("d_back_idle", d_busy, 0);

    // Abort at cycle 100 of a second run.
    @(negedge clk); d_start = 1'b1;
    @(negedge clk); d_start = 1'b0;
    repeat (99) @(negedge clk);
    check("d_busy_before_abort", d_busy, 1);
    d_abort = 1'b1;
    @(posedge clk); #1;
    check("d_abort_busy", d_busy, 0);
    check("d_abort_w1_en", d_w1_en, 0);
    @(negedge clk); d_abort = 1'b0;
    repeat (50) @(negedge clk);
    check("d_abort_no_done", d_done_cnt, 1);
    check("d_abort_predicted", d_predicted, 7);
    check("d_abort_best", d_best_score, 100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mlp_engine.md
# mlp_engine

Parametrised two-layer MLP inference engine (Linear → ReLU → requantise → Linear → argmax) that succeeds the fixed 784-32-10 classifier core. It sits behind the AXI-Lite register slave of the MicroBlaze peripheral and reads weights and biases from external 1-cycle-latency block ROMs. New capabilities over the fixed core:
- every dimension and width is a parameter;
- saturating hidden-activation requantisation;
- a buffered per-class score read port;
- abort;
- a sticky pixel-write error flag.

## Interface

Parameters:
- N_IN, 784, input vector length
- H, 32, hidden neurons
- N_OUT, 10, output classes
- X_W, 8, unsigned pixel width
- W_W, 8, signed weight width (both layers)
- B_W, 32, signed bias width (both layers)
- ACC_W, 48, signed accumulator / score width
- A_W, 16, signed hidden-activation width after requantisation
- SHIFT, 8, arithmetic right shift applied to hidden pre-activations

Ports (`AW(x)` = `$clog2(x)`):
- `clk` in 1: single clock
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: rising edge (registered, sampled in IDLE) launches inference
- `abort` in 1: level; cancels a running inference
- `busy` out 1: high in every state except IDLE and DONE
- `done` out 1: one-cycle pulse when `predicted` and scores are valid
- `pix_we` in 1: pixel write strobe
- `pix_addr` in AW(N_IN): pixel index
- `pix_data` in X_W: pixel value
- `pix_err` out 1: sticky; a pixel write was rejected
- `w1_en` / `w1_addr` / `w1_dout`: out 1 / out AW(N_IN*H) / in W_W; layer-1 weight at `j*N_IN+i`
- `b1_en` / `b1_addr` / `b1_dout`: out 1 / out AW(H) / in B_W
- `w2_en` / `w2_addr` / `w2_dout`: out 1 / out AW(H*N_OUT) / in W_W; layer-2 weight at `k*H+j`
- `b2_en` / `b2_addr` / `b2_dout`: out 1 / out AW(N_OUT) / in B_W
- `predicted` out AW(N_OUT): argmax class
- `best_score` out ACC_W: score of the predicted class
- `score_rd_addr` in AW(N_OUT): score buffer index
- `score_rd_data` out ACC_W: combinational read of `score[score_rd_addr]`; returns 0 for an out-of-range index

## Operation

- **States:** IDLE, L1_PRIME, L1_MAC, L1_STORE, L2_PRIME, L2_MAC, L2_FINISH, DONE.
- **Pixel buffer:** `pix_we` writes only in IDLE or DONE with `pix_addr < N_IN`. Any other write is dropped and sets `pix_err`. `pix_err` clears on an accepted start.
- **Start:** IDLE with a start rising edge:
  - clear the accumulator and score buffer;
  - issue `w1_addr = 0`, `b1_addr = 0` with enables high;
  - go to L1_PRIME.
  - Start edges while busy are ignored.
- **Layer 1, per neuron j:**
  - L1_PRIME: one cycle waiting for ROM data.
  - L1_MAC: N_IN cycles of `acc += w1 * x` (signed × zero-extended unsigned).
  - L1_STORE:
    - `h = acc + sext(b1)`;
    - `a[j] = 0` if `h ≤ 0`, else `min(h >>> SHIFT, 2^(A_W-1)-1)`;
    - then next j → L1_PRIME, or after j = H-1 → L2_PRIME.
- **Layer 2, per class k:**
  - L2_PRIME: one cycle.
  - L2_MAC: H cycles of `acc += w2 * a[j]`.
  - L2_FINISH:
    - `score[k] = acc + sext(b2)`;
    - k = 0 unconditionally initialises best;
    - for k > 0, best updates only if `score > best` (strict, so ties keep the lowest index);
    - then next k, or DONE.
- **Arithmetic:** two's complement at ACC_W, wrapping modulo 2^ACC_W; no saturation outside requantisation.
- **DONE:**
  - updates `predicted` and `best_score` together with the `done` pulse;
  - drops all ROM enables;
  - moves to IDLE on the next cycle;
  - a new start requires a fresh rising edge.
- **Abort** (any busy state): next state IDLE, enables low, no `done`. `predicted` and `best_score` keep their previous values; the score buffer content is undefined.
- **Reset:** all outputs 0, including enables, addresses, `busy`, `done`, `pix_err`, `predicted` and `best_score`. The score buffer is 0. Reset asserted mid-operation takes effect immediately, with no `done`.

## Timing

- ROM read latency is 1 cycle: `*_dout` is used the cycle after address/enable. Enables stay high for the whole layer.
- Total latency, from the clock edge sampling the start edge to the `done` pulse: `H*(N_IN+2) + N_OUT*(H+2) + 1` cycles. Defaults: 25 493 cycles.
- `busy` rises on the cycle after the start is sampled and falls in the same cycle `done` rises.
- `score_rd_data` is stable from `done` until the next accepted start.

## Test plan

- **Tie-break:** N_IN=4, H=2, N_OUT=3, all pixels 0, b2 = {5, 9, 9} → `predicted` = 1, `best_score` = 9, `score_rd_data` = 5, 9, 9 for addresses 0..2.
- **Saturation:** same dims, SHIFT=0, A_W=8, pixels 255, w1 = 127, b1 = 0 → `a[j]` = 127 (pre-activation 129 540). With w2 = 1, b2 = 0 → every score = 254 and `predicted` = 0.
- **ReLU:** w1 = -1, pixels 10, b1 = 0 → `a[j]` = 0. Scores equal b2 = {-3, -1, -7} → `predicted` = 1, `best_score` = -1.
- **Default parameters:** `done` is exactly 25 493 cycles after the start sample; `busy` high throughout; exactly one `done` pulse.
- **Abort and blocked write:** assert `abort` at cycle 100 → IDLE within 1 cycle, no `done`, `predicted` unchanged. A `pix_we` while busy leaves the buffer unchanged and sets `pix_err` = 1; the next start clears it.
- **Mid-run reset:** `rst_n` low mid-L2 → all outputs 0 asynchronously. A subsequent full run gives the golden-model result.
